video_mode_sequencer: RTL and testbench

//  Owns the video_mixer run-time config (scanlines, scandoubler_disable, hq2x, ypbpr, ypbpr_full).

---
 rtl/video_mode_sequencer.sv | 234 +++++++++++++++++++++++
 tb/tb_video_mode_sequencer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_mode_sequencer.sv
// video_mode_sequencer: owns the video_mixer run-time config and applies requests on VSync
// boundaries, muting around structural changes. VIDEO_MODE_SEQ_WDOG_EN adds a lost-VSync watchdog.
module video_mode_sequencer #(
  parameter logic [3:0]  MUTE_FRAMES   = 4'd2,
  parameter logic [3:0]  SETTLE_FRAMES = 4'd1,
  parameter logic [23:0] WDOG_CYCLES   = 24'd2000000
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       VSync,
  input  logic       cfg_valid,
  input  logic [1:0] cfg_scanlines,
  input  logic       cfg_sd_disable,
  input  logic       cfg_hq2x,
  input  logic       cfg_ypbpr,
  input  logic       cfg_ypbpr_full,
  output logic [1:0] scanlines,
  output logic       scandoubler_disable,
  output logic       hq2x,
  output logic       ypbpr,
  output logic       ypbpr_full,
  output logic       mute,
  output logic       busy,
  output logic       vs_lost
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MUTE_WAIT = 2'd1,
    APPLY     = 2'd2,
    SETTLE    = 2'd3
  } state_e;

  if (MUTE_FRAMES == 4'd0 || SETTLE_FRAMES == 4'd0 || WDOG_CYCLES < 24'd2) begin : g_bad_params
    $error("video_mode_sequencer: MUTE_FRAMES/SETTLE_FRAMES must be >= 1 and WDOG_CYCLES >= 2");
  end

  state_e     state_q, state_d;
  logic       vs_d_q;
  logic [3:0] frame_cnt_q, frame_cnt_d, frame_cnt_inc;
  logic       pend_q, pend_d;
  logic       mute_q, mute_d;
  logic       busy_q, busy_d;

  logic [1:0] sh_scanlines_q, sh_scanlines_d;
  logic       sh_sd_q, sh_sd_d;
  logic       sh_hq2x_q, sh_hq2x_d;
  logic       sh_ypbpr_q, sh_ypbpr_d;
  logic       sh_ypbpr_full_q, sh_ypbpr_full_d;

  logic [1:0] scanlines_q, scanlines_d;
  logic       sd_q, sd_d;
  logic       hq2x_q, hq2x_d;
  logic       ypbpr_q, ypbpr_d;
  logic       ypbpr_full_q, ypbpr_full_d;

  logic vs_rise;
  logic tick;
  logic struct_diff;
  logic cosm_diff;

  assign vs_rise = VSync & ~vs_d_q;

`ifdef VIDEO_MODE_SEQ_WDOG_EN
  logic [23:0] wdog_cnt_q, wdog_cnt_d;
  logic        vs_lost_q, vs_lost_d;
  logic        wdog_active;
  logic        wdog_fire;

  // The watchdog only matters while a muted sequence is waiting on frames; elsewhere it is parked at 0.
  always_comb begin
    wdog_active = (state_q == MUTE_WAIT) || (state_q == SETTLE);
    wdog_fire   = wdog_active && !vs_rise && (wdog_cnt_q == WDOG_CYCLES - 24'd1);
    wdog_cnt_d  = wdog_cnt_q;
    vs_lost_d   = vs_lost_q;
    if (vs_rise || !wdog_active || wdog_fire) begin
      wdog_cnt_d = '0;
    end else if (wdog_cnt_q != '1) begin
      wdog_cnt_d = wdog_cnt_q + 24'd1;
    end
    if (vs_rise) begin
      vs_lost_d = 1'b0;
    end else if (wdog_fire) begin
      vs_lost_d = 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt_q <= '0;
      vs_lost_q  <= 1'b0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
      vs_lost_q  <= vs_lost_d;
    end
  end

  assign tick    = vs_rise | wdog_fire;
  assign vs_lost = vs_lost_q;
`else
  assign tick    = vs_rise;
  assign vs_lost = 1'b0;
`endif

  always_comb begin
    struct_diff   = {sh_sd_q, sh_hq2x_q, sh_ypbpr_q} != {sd_q, hq2x_q, ypbpr_q};
    cosm_diff     = {sh_scanlines_q, sh_ypbpr_full_q} != {scanlines_q, ypbpr_full_q};
    frame_cnt_inc = (frame_cnt_q == 4'hF) ? frame_cnt_q : frame_cnt_q + 4'd1;

    state_d         = state_q;
    frame_cnt_d     = frame_cnt_q;
    pend_d          = pend_q;
    mute_d          = mute_q;
    scanlines_d     = scanlines_q;
    sd_d            = sd_q;
    hq2x_d          = hq2x_q;
    ypbpr_d         = ypbpr_q;
    ypbpr_full_d    = ypbpr_full_q;
    sh_scanlines_d  = sh_scanlines_q;
    sh_sd_d         = sh_sd_q;
    sh_hq2x_d       = sh_hq2x_q;
    sh_ypbpr_d      = sh_ypbpr_q;
    sh_ypbpr_full_d = sh_ypbpr_full_q;

    unique case (state_q)
      IDLE: begin
        if (pend_q && struct_diff) begin
          state_d     = MUTE_WAIT;
          mute_d      = 1'b1;
          frame_cnt_d = '0;
        end else if (pend_q && vs_rise) begin
          scanlines_d  = sh_scanlines_q;
          ypbpr_full_d = sh_ypbpr_full_q;
          pend_d       = 1'b0;
        end else if (pend_q && !cosm_diff) begin
          pend_d = 1'b0;
        end
      end
      MUTE_WAIT: begin
        if (tick) begin
          frame_cnt_d = frame_cnt_inc;
          if (frame_cnt_q == MUTE_FRAMES - 4'd1) begin
            state_d = APPLY;
          end
        end
      end
      APPLY: begin
        scanlines_d  = sh_scanlines_q;
        sd_d         = sh_sd_q;
        hq2x_d       = sh_hq2x_q;
        ypbpr_d      = sh_ypbpr_q;
        ypbpr_full_d = sh_ypbpr_full_q;
        pend_d       = 1'b0;
        frame_cnt_d  = '0;
        state_d      = SETTLE;
      end
      SETTLE: begin
        if (tick) begin
          frame_cnt_d = frame_cnt_inc;
          if (frame_cnt_q == SETTLE_FRAMES - 4'd1) begin
            // A structural request queued during settle chains straight into a new mute window.
            if (pend_q && struct_diff) begin
              state_d     = MUTE_WAIT;
              frame_cnt_d = '0;
            end else begin
              state_d = IDLE;
              mute_d  = 1'b0;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A new request always wins over any pend clear on the same edge.
    if (cfg_valid) begin
      sh_scanlines_d  = cfg_scanlines;
      sh_sd_d         = cfg_sd_disable;
      sh_hq2x_d       = cfg_hq2x;
      sh_ypbpr_d      = cfg_ypbpr;
      sh_ypbpr_full_d = cfg_ypbpr_full;
      pend_d          = 1'b1;
    end

    busy_d = (state_d != IDLE) | pend_d;
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      vs_d_q          <= 1'b0;
      frame_cnt_q     <= '0;
      pend_q          <= 1'b0;
      mute_q          <= 1'b0;
      busy_q          <= 1'b0;
      sh_scanlines_q  <= '0;
      sh_sd_q         <= 1'b0;
      sh_hq2x_q       <= 1'b0;
      sh_ypbpr_q      <= 1'b0;
      sh_ypbpr_full_q <= 1'b0;
      scanlines_q     <= '0;
      sd_q            <= 1'b0;
      hq2x_q          <= 1'b0;
      ypbpr_q         <= 1'b0;
      ypbpr_full_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      vs_d_q          <= VSync;
      frame_cnt_q     <= frame_cnt_d;
      pend_q          <= pend_d;
      mute_q          <= mute_d;
      busy_q          <= busy_d;
      sh_scanlines_q  <= sh_scanlines_d;
      sh_sd_q         <= sh_sd_d;
      sh_hq2x_q       <= sh_hq2x_d;
      sh_ypbpr_q      <= sh_ypbpr_d;
      sh_ypbpr_full_q <= sh_ypbpr_full_d;
      scanlines_q     <= scanlines_d;
      sd_q            <= sd_d;
      hq2x_q          <= hq2x_d;
      ypbpr_q         <= ypbpr_d;
      ypbpr_full_q    <= ypbpr_full_d;
    end
  end

  assign scanlines           = scanlines_q;
  assign scandoubler_disable = sd_q;
  assign hq2x                = hq2x_q;
  assign ypbpr               = ypbpr_q;
  assign ypbpr_full          = ypbpr_full_q;
  assign mute                = mute_q;
  assign busy                = busy_q;

endmodule

// File: tb/tb_video_mode_sequencer.sv
// Scoreboard bench for video_mode_sequencer: random requests against a frame-counting model;
// a monitor pops the expected config whenever the applied outputs change.
module tb_video_mode_sequencer;

  localparam logic [3:0] MUTE_F   = 4'd2;
  localparam logic [3:0] SETTLE_F = 4'd1;
`ifdef VIDEO_MODE_SEQ_WDOG_EN
  localparam logic [23:0] WDOG_C = 24'd100;
`else
  localparam logic [23:0] WDOG_C = 24'd2000000;
`endif

  logic       clk_sys = 1'b0;
  logic       rst_n = 1'b1;
  logic       VSync = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [1:0] cfg_scanlines = '0;
  logic       cfg_sd_disable = 1'b0;
  logic       cfg_hq2x = 1'b0;
  logic       cfg_ypbpr = 1'b0;
  logic       cfg_ypbpr_full = 1'b0;
  logic [1:0] scanlines;
  logic       scandoubler_disable;
  logic       hq2x;
  logic       ypbpr;
  logic       ypbpr_full;
  logic       mute;
  logic       busy;
  logic       vs_lost;

  video_mode_sequencer #(
    .MUTE_FRAMES  (MUTE_F),
    .SETTLE_FRAMES(SETTLE_F),
    .WDOG_CYCLES  (WDOG_C)
  ) dut (
    .clk_sys            (clk_sys),
    .rst_n              (rst_n),
    .VSync              (VSync),
    .cfg_valid          (cfg_valid),
    .cfg_scanlines      (cfg_scanlines),
    .cfg_sd_disable     (cfg_sd_disable),
    .cfg_hq2x           (cfg_hq2x),
    .cfg_ypbpr          (cfg_ypbpr),
    .cfg_ypbpr_full     (cfg_ypbpr_full),
    .scanlines          (scanlines),
    .scandoubler_disable(scandoubler_disable),
    .hq2x               (hq2x),
    .ypbpr              (ypbpr),
    .ypbpr_full         (ypbpr_full),
    .mute               (mute),
    .busy               (busy),
    .vs_lost            (vs_lost)
  );

  always #5 clk_sys = ~clk_sys;

  // Config vector layout: {scanlines[1:0], sd_disable, hq2x, ypbpr, ypbpr_full}; [3:1] is structural.
  logic [5:0] out_vec;
  assign out_vec = {scanlines, scandoubler_disable, hq2x, ypbpr, ypbpr_full};

  int checks = 0;
  int errors = 0;
  logic [5:0] exp_q[$];
  logic [5:0] model_applied = '0;

  logic [5:0] prev_out = '0;
  logic       mute_prev = 1'b0;
  int         mute_rises = 0;
  int         mute_falls = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_sys) begin
    if (!rst_n) begin
      prev_out  = out_vec;
      mute_prev = mute;
    end else begin
      if (out_vec !== prev_out) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_apply: got %0h expected no change from %0h", out_vec, prev_out);
        end else begin
          check("apply_value", {26'd0, out_vec}, {26'd0, exp_q.pop_front()});
        end
        if (out_vec[3:1] !== prev_out[3:1]) check("struct_change_under_mute", {31'd0, mute}, 1);
        prev_out = out_vec;
      end
      if (!mute_prev && mute) mute_rises++;
      if (mute_prev && !mute) mute_falls++;
      mute_prev = mute;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic send_cfg(input logic [5:0] v);
    {cfg_scanlines, cfg_sd_disable, cfg_hq2x, cfg_ypbpr, cfg_ypbpr_full} = v;
    cfg_valid = 1'b1;
    cyc(1);
    cfg_valid = 1'b0;
    {cfg_scanlines, cfg_sd_disable, cfg_hq2x, cfg_ypbpr, cfg_ypbpr_full} = 6'($urandom);
  endtask

  task automatic vs_pulse();
    VSync = 1'b1;
    cyc(1);
    VSync = 1'b0;
    cyc(1 + int'($urandom_range(0, 3)));
  endtask

  task automatic noop();
    send_cfg(model_applied);
    cyc(1);
    check("noop_busy_clears", {31'd0, busy}, 0);
    check("noop_no_mute", {31'd0, mute}, 0);
  endtask

  // Cosmetic fields change exactly on the next VSync rise with no mute.
  task automatic cosmetic(input logic [1:0] scan, input logic yf);
    logic [5:0] old, v;
    int r0;
    old = model_applied;
    v   = {scan, old[3:1], yf};
    if (v == old) begin
      noop();
    end else begin
      r0 = mute_rises;
      exp_q.push_back(v);
      model_applied = v;
      send_cfg(v);
      cyc(1 + int'($urandom_range(0, 3)));
      check("cosm_held_before_vs", {26'd0, out_vec}, {26'd0, old});
      check("cosm_busy_pending", {31'd0, busy}, 1);
      VSync = 1'b1;
      cyc(1);
      VSync = 1'b0;
      check("cosm_applied_on_vs_rise", {26'd0, out_vec}, {26'd0, v});
      check("cosm_busy_clear", {31'd0, busy}, 0);
      cyc(1 + int'($urandom_range(0, 3)));
      check("cosm_never_muted", 32'(mute_rises - r0), 0);
    end
  endtask

  // mode 0: plain; mode 1: newer request during MUTE_WAIT; mode 2: structural request during SETTLE.
  task automatic structural(input int mode);
    logic [5:0] old, a, b, c;
    int r0, f0;
    old = model_applied;
    do a = 6'($urandom); while (a[3:1] == old[3:1]);
    b  = 6'($urandom);
    r0 = mute_rises;
    f0 = mute_falls;
    if (mode != 1) begin
      exp_q.push_back(a);
      model_applied = a;
    end
    send_cfg(a);
    cyc(1);
    check("mute_one_cycle_after_req", {31'd0, mute}, 1);
    for (int k = 1; k <= int'(MUTE_F); k++) begin
      check("held_during_mute_frames", {26'd0, out_vec}, {26'd0, old});
      vs_pulse();
      if (mode == 1 && k == 1) begin
        if (b != old) exp_q.push_back(b);
        model_applied = b;
        send_cfg(b);
      end
    end
    check("applied_after_mute_frames", {26'd0, out_vec}, {26'd0, model_applied});
    check("busy_in_settle", {31'd0, busy}, 1);
    if (mode == 2) begin
      do c = 6'($urandom); while (c[3:1] == model_applied[3:1]);
      old = model_applied;
      exp_q.push_back(c);
      model_applied = c;
      send_cfg(c);
      for (int j = 1; j <= int'(SETTLE_F); j++) vs_pulse();
      check("mute_kept_into_second_seq", {31'd0, mute}, 1);
      for (int k = 1; k <= int'(MUTE_F); k++) begin
        check("held_during_second_mute", {26'd0, out_vec}, {26'd0, old});
        vs_pulse();
      end
      check("second_seq_applied", {26'd0, out_vec}, {26'd0, c});
    end
    for (int j = 1; j <= int'(SETTLE_F); j++) begin
      check("mute_held_in_settle", {31'd0, mute}, 1);
      vs_pulse();
    end
    check("mute_released", {31'd0, mute}, 0);
    check("busy_released", {31'd0, busy}, 0);
    check("single_mute_window_rise", 32'(mute_rises - r0), 1);
    check("single_mute_window_fall", 32'(mute_falls - f0), 1);
  endtask

  task automatic reset_mid_sequence();
    logic [5:0] a;
    do a = 6'($urandom); while (a[3:1] == model_applied[3:1]);
    send_cfg(a);
    cyc(1);
    vs_pulse();
    check("mute_before_reset", {31'd0, mute}, 1);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {26'd0, out_vec}, 0);
    check("async_reset_mute", {31'd0, mute}, 0);
    check("async_reset_busy", {31'd0, busy}, 0);
    cyc(3);
    rst_n = 1'b1;
    model_applied = '0;
    cyc(2);
    check("after_reset_outputs", {26'd0, out_vec}, 0);
    check("after_reset_idle", {31'd0, busy}, 0);
  endtask

`ifdef VIDEO_MODE_SEQ_WDOG_EN
  // Without VSync each synthetic tick takes WDOG_C cycles, so the apply lands near MUTE_F*WDOG_C.
  task automatic wdog_test();
    logic [5:0] old, a;
    int n;
    old = model_applied;
    do a = 6'($urandom); while (a[3:1] == old[3:1]);
    exp_q.push_back(a);
    model_applied = a;
    send_cfg(a);
    n = 0;
    while (out_vec === old && n < 1000) begin
      cyc(1);
      n++;
    end
    check("wdog_apply_cycles_in_window", {31'd0, (n >= 190 && n <= 210)}, 1);
    check("wdog_vs_lost_set", {31'd0, vs_lost}, 1);
    vs_pulse();
    check("wdog_vs_lost_cleared", {31'd0, vs_lost}, 0);
    check("wdog_mute_released", {31'd0, mute}, 0);
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    #1 rst_n = 1'b0;
    #1;
    check("reset_outputs", {26'd0, out_vec}, 0);
    cyc(3);
    check("reset_outputs_held", {26'd0, out_vec}, 0);
    check("reset_mute", {31'd0, mute}, 0);
    check("reset_busy", {31'd0, busy}, 0);
    check("reset_vs_lost", {31'd0, vs_lost}, 0);
    rst_n = 1'b1;
    cyc(2);

    cosmetic(2'd2, 1'b0);
    structural(0);
    structural(1);
    structural(2);
    reset_mid_sequence();
    noop();

    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 5))
        0, 1:    cosmetic(2'($urandom), 1'($urandom));
        2:       structural(0);
        3:       structural(1);
        4:       structural(2);
        default: noop();
      endcase
    end

`ifdef VIDEO_MODE_SEQ_WDOG_EN
    wdog_test();
`else
    check("vs_lost_tied_low", {31'd0, vs_lost}, 0);
`endif

    cyc(3);
    check("scoreboard_drained", 32'(exp_q.size()), 0);
    check("final_outputs_match_model", {26'd0, out_vec}, {26'd0, model_applied});
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
